// File: rtl/i2s_frame_packer.sv
// Store-and-forward packer: frames from the I2S byte stream become headed AXI-Stream packets.
// Define I2S_FRAME_PACKER_CRC_EN to append a CRC-8 trailer byte to every packet.
module i2s_frame_packer #(
  parameter int         DEPTH = 256,
  parameter logic [7:0] CH_ID = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [3:0]  i_dst_fpga_index,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] o_drop_num,
  output logic [31:0] o_pkt_num
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    ACCEPT,
    DISCARD
  } in_state_t;

  typedef enum logic [2:0] {
    IDLE,
    H0,
    H1,
    H2,
    H3,
    DATA,
    CRC
  } out_state_t;

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fill;
  logic [PW-1:0] frames;
  logic          full;
  logic          wr_en;
  logic          ovf;
  logic          commit;
  logic          done;
  in_state_t     in_state;
  in_state_t     in_next;

  assign fill   = wr_ptr - rd_ptr;
  assign full   = (fill == PW'(DEPTH));
  assign wr_en  = i_enable && (in_state == ACCEPT)
                  && s_axis_tvalid && !full;
  assign ovf    = i_enable && (in_state == ACCEPT)
                  && s_axis_tvalid && full;
  assign commit = wr_en && s_axis_tlast;

  always_comb begin
    in_next = in_state;
    if (!i_enable) begin
      in_next = DISCARD;
    end else if (in_state == DISCARD) begin
      if (s_axis_tvalid && s_axis_tlast) begin
        in_next = ACCEPT;
      end
    end else if (ovf && !s_axis_tlast) begin
      in_next = DISCARD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state <= ACCEPT;
    end else begin
      in_state <= in_next;
    end
  end

  // Uncommitted bytes are rewound on disable or overflow; only a
  // tlast write moves commit_ptr, so readers never see partial frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      o_drop_num <= '0;
    end else if (!i_enable) begin
      wr_ptr <= commit_ptr;
    end else if (ovf) begin
      wr_ptr <= commit_ptr;
      if (o_drop_num != 32'hFFFF_FFFF) begin
        o_drop_num <= o_drop_num + 32'd1;
      end
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (s_axis_tlast) begin
        commit_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frames <= '0;
    end else if (commit && !done) begin
      frames <= frames + PW'(1);
    end else if (!commit && done) begin
      frames <= frames - PW'(1);
    end
  end

  // Two-deep read pipe: ram_q holds the registered RAM output and pf is
  // the fall-through head presented in DATA.
  logic       rv;
  logic       pv;
  logic [8:0] ram_q;
  logic [8:0] pf;
  logic       have_data;
  logic       pop;
  logic       load_pf;
  logic       issue;
  out_state_t state;
  out_state_t state_nx;

  assign have_data = (rd_ptr != commit_ptr);
  assign pop       = (state == DATA) && pv && m_axis_tready;
  assign load_pf   = rv && (!pv || pop);
  assign issue     = have_data && (!rv || load_pf);

  always_ff @(posedge clk) begin
    if (issue) begin
      ram_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      rv     <= 1'b0;
      pv     <= 1'b0;
      pf     <= '0;
    end else begin
      if (issue) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      rv <= issue || (rv && !load_pf);
      if (load_pf) begin
        pf <= ram_q;
        pv <= 1'b1;
      end else if (pop) begin
        pv <= 1'b0;
      end
    end
  end

  logic [3:0]  dst_q;
  logic [15:0] seq;

`ifdef I2S_FRAME_PACKER_CRC_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      crc <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      crc <= crc8(crc, m_axis_tdata);
    end
  end
`endif

  always_comb begin
    state_nx      = state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        if (frames != '0) begin
          state_nx = H0;
        end
      end
      H0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {4'hA, dst_q};
        if (m_axis_tready) state_nx = H1;
      end
      H1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = CH_ID;
        if (m_axis_tready) state_nx = H2;
      end
      H2: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = seq[15:8];
        if (m_axis_tready) state_nx = H3;
      end
      H3: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = seq[7:0];
        if (m_axis_tready) state_nx = DATA;
      end
      DATA: begin
        m_axis_tvalid = pv;
        m_axis_tdata  = pf[7:0];
`ifdef I2S_FRAME_PACKER_CRC_EN
        if (pop && pf[8]) state_nx = CRC;
`else
        m_axis_tlast = pf[8];
        if (pop && pf[8]) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
`endif
      end
`ifdef I2S_FRAME_PACKER_CRC_EN
      CRC: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = crc;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dst_q     <= '0;
      seq       <= '0;
      o_pkt_num <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == H0) begin
        dst_q <= i_dst_fpga_index;
      end
      if (done) begin
        seq       <= seq + 16'd1;
        o_pkt_num <= o_pkt_num + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_packer.sv
// Randomised self-checking bench for i2s_frame_packer against a packet-queue model.
// Honours I2S_FRAME_PACKER_CRC_EN when the design is built with the trailer.
module tb_i2s_frame_packer;

  localparam int         DEPTH = 32;
  localparam logic [7:0] CH    = 8'd5;
`ifdef I2S_FRAME_PACKER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef logic [7:0] q8_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  dst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic [31:0] drop_num;
  logic [31:0] pkt_num;

  i2s_frame_packer #(.DEPTH(DEPTH), .CH_ID(CH)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_enable         (en),
    .i_dst_fpga_index (dst),
    .s_axis_tvalid    (s_valid),
    .s_axis_tdata     (s_data),
    .s_axis_tlast     (s_last),
    .m_axis_tvalid    (m_valid),
    .m_axis_tdata     (m_data),
    .m_axis_tlast     (m_last),
    .m_axis_tready    (m_ready),
    .o_drop_num       (drop_num),
    .o_pkt_num        (pkt_num)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  beat_t       cap_q[$];
  int          errs = 0;
  int          checks = 0;
  logic [15:0] mdl_seq;
  int          mdl_pkts;
  int          mdl_drops;
  int          seen_pkts;
  int          rdy_mode;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c,
                                          input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      if (r[7]) r = {r[6:0], 1'b0} ^ 8'h07;
      else      r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic q8_t mk(input int len, input bit inc);
    q8_t f;
    for (int i = 0; i < len; i++) begin
      if (inc) f.push_back(8'(i));
      else     f.push_back(8'($urandom_range(0, 255)));
    end
    return f;
  endfunction

  // Model: a kept frame becomes header + data (+ crc) on the wire.
  task automatic push_pkt(input q8_t f);
    q8_t        p;
    logic [7:0] c;
    c = 8'h00;
    p.push_back({4'hA, dst});
    p.push_back(CH);
    p.push_back(mdl_seq[15:8]);
    p.push_back(mdl_seq[7:0]);
    foreach (f[i]) p.push_back(f[i]);
    foreach (p[i]) begin
      c = crc_step(c, p[i]);
      exp_q.push_back('{d: p[i], l: (i == p.size() - 1) && !CRC_ON});
    end
    if (CRC_ON) exp_q.push_back('{d: c, l: 1'b1});
    mdl_seq = mdl_seq + 16'd1;
    mdl_pkts++;
  endtask

  task automatic send(input q8_t f, input int en_at, input logic en_v);
    foreach (f[i]) begin
      @(posedge clk);
      #1;
      if (i == en_at) en = en_v;
      s_valid = 1'b1;
      s_data  = f[i];
      s_last  = (i == f.size() - 1);
    end
  endtask

  task automatic idle_in(input int n);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: left %0d beats want 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    exp_q.delete();
    cap_q.delete();
    mdl_seq   = '0;
    mdl_pkts  = 0;
    mdl_drops = 0;
    seen_pkts = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_tdata", {24'd0, m_data}, 32'd0);
    chk("rst_tlast", {31'd0, m_last}, 32'd0);
    chk("rst_drop", drop_num, 32'd0);
    chk("rst_pkt", pkt_num, 32'd0);
  endtask

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Per-cycle compare against the model queue plus stall stability.
  initial begin
    logic       stall;
    logic [8:0] stall_v;
    beat_t      b;
    stall = 1'b0;
    stall_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", {31'd0, m_valid}, 32'd1);
          chk("hold_data", {23'd0, m_last, m_data}, {23'd0, stall_v});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL extra_beat: got %h want none", m_data);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", {24'd0, m_data}, {24'd0, b.d});
            chk("beat_last", {31'd0, m_last}, {31'd0, b.l});
            cap_q.push_back('{d: m_data, l: m_last});
            if (m_last) seen_pkts++;
          end
        end
        stall   = m_valid && !m_ready;
        stall_v = {m_last, m_data};
      end
    end
  end

  initial begin
    q8_t f;
    int  n;
    rst = 1'b1;
    en = 1'b1;
    dst = 4'd3;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    rdy_mode = 1;
    do_reset();

    // Incrementing 8-byte frame with tready high, pinned literally.
    f = mk(8, 1'b1);
    push_pkt(f);
    send(f, -1, 1'b1);
    idle_in(0);
    drain();
    chk("p1_len", cap_q.size(), CRC_ON ? 32'd13 : 32'd12);
    chk("p1_h0", {24'd0, cap_q[0].d}, 32'hA3);
    chk("p1_h1", {24'd0, cap_q[1].d}, 32'h05);
    chk("p1_h2", {24'd0, cap_q[2].d}, 32'h00);
    chk("p1_h3", {24'd0, cap_q[3].d}, 32'h00);
    chk("p1_d7", {24'd0, cap_q[11].d}, 32'h07);
    chk("p1_last7", {31'd0, cap_q[11].l}, CRC_ON ? 32'd0 : 32'd1);
    chk("p1_pkt", pkt_num, 32'd1);

    // Three back-to-back frames held off by tready for 50 cycles.
    rdy_mode = 0;
    for (int k = 0; k < 3; k++) begin
      f = mk(4, 1'b0);
      push_pkt(f);
      send(f, -1, 1'b1);
    end
    idle_in(50);
    rdy_mode = 1;
    drain();
    chk("b2b_pkt", pkt_num, 32'd4);
    chk("b2b_drop", drop_num, 32'd0);

    // 32-byte frame under random tready.
    rdy_mode = 2;
    f = mk(32, 1'b0);
    push_pkt(f);
    send(f, -1, 1'b1);
    idle_in(0);
    drain();

    // Enable dropped mid-frame and restored mid-next-frame.
    rdy_mode = 1;
    send(mk(10, 1'b0), 4, 1'b0);
    send(mk(10, 1'b0), 5, 1'b1);
    idle_in(2);
    f = mk(7, 1'b0);
    push_pkt(f);
    send(f, -1, 1'b1);
    idle_in(0);
    drain();
    chk("en_drop", drop_num, 32'd0);
    chk("en_pkt", pkt_num, 32'd6);

    // Overflow on a fresh buffer, then a frame that follows it.
    do_reset();
    rdy_mode = 0;
    send(mk(40, 1'b0), -1, 1'b1);
    idle_in(3);
    mdl_drops++;
    chk("ovf_drop", drop_num, 32'(mdl_drops));
    chk("ovf_nopkt", {31'd0, m_valid}, 32'd0);
    cap_q.delete();
    f = mk(6, 1'b0);
    push_pkt(f);
    send(f, -1, 1'b1);
    idle_in(5);
    rdy_mode = 1;
    drain();
    chk("ovf_seq_hi", {24'd0, cap_q[2].d}, 32'h00);
    chk("ovf_seq_lo", {24'd0, cap_q[3].d}, 32'h00);
    chk("ovf_pkt", pkt_num, 32'd1);

    // Frame that exactly fills the buffer is kept.
    rdy_mode = 0;
    f = mk(DEPTH, 1'b0);
    push_pkt(f);
    send(f, -1, 1'b1);
    idle_in(5);
    rdy_mode = 1;
    drain();
    chk("fit_drop", drop_num, 32'(mdl_drops));

    // Minimal frame to a different destination.
    dst = 4'd0;
    f = mk(1, 1'b1);
    push_pkt(f);
    send(f, -1, 1'b1);
    idle_in(0);
    drain();
    dst = 4'd3;

    // Random stream with random tready, occupancy kept below DEPTH.
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      n = 0;
      while ((mdl_pkts - seen_pkts) > 2 && n < 2000) begin
        @(posedge clk);
        n++;
      end
      #1;
      f = mk($urandom_range(1, 8), 1'b0);
      push_pkt(f);
      send(f, -1, 1'b1);
      idle_in($urandom_range(0, 3));
    end
    drain();
    chk("rnd_pkt", pkt_num, 32'(mdl_pkts));
    chk("rnd_drop", drop_num, 32'(mdl_drops));

    // Reset while a packet is stalled mid-flight.
    rdy_mode = 0;
    f = mk(4, 1'b0);
    push_pkt(f);
    send(f, -1, 1'b1);
    idle_in(10);
    chk("stuck_valid", {31'd0, m_valid}, 32'd1);
    do_reset();
    rdy_mode = 1;
    f = mk(3, 1'b0);
    push_pkt(f);
    send(f, -1, 1'b1);
    idle_in(0);
    drain();
    chk("post_rst_pkt", pkt_num, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/i2s_frame_packer.md
Name: i2s_frame_packer

Overview:
- Downstream of the I2S capture stage. Consumes one channel's byte stream: 8-bit tdata, tvalid, tlast at end of each TDM frame; no backpressure.
- Store-and-forward buffers each complete frame, then emits it as a packet on a back-pressured AXI-Stream master toward the inter-FPGA transport.
- Each packet carries a 4-byte header: destination FPGA index, channel id, sequence number.
- Frames that cannot be buffered whole are dropped and counted.

Parameters:
- DEPTH, 256: data buffer entries (bytes); power of two, 16..4096.
- CH_ID, 0: 8-bit channel id placed in header byte 1.

Ports:
- clk  input  1  core clock; also the clock of the s_axis stream.
- rst  input  1  synchronous reset, active-high.
- i_enable  input  1  packer enable, already synchronous to clk.
- i_dst_fpga_index  input  4  destination FPGA index for header byte 0.
- s_axis_tvalid  input  1  input byte valid.
- s_axis_tdata  input  8  input byte.
- s_axis_tlast  input  1  last byte of frame.
- m_axis_tvalid  output  1  packet byte valid.
- m_axis_tdata  output  8  packet byte.
- m_axis_tlast  output  1  last byte of packet.
- m_axis_tready  input  1  downstream ready.
- o_drop_num  output  32  count of dropped frames, saturating.
- o_pkt_num  output  32  count of packets fully emitted, wrapping.

Behaviour:
- Reset values:
  - All outputs 0.
  - Buffer empty; write pointer, commit pointer and read pointer 0.
  - Sequence counter 0; FSM in IDLE; input side in ACCEPT state.
- Buffer: DEPTH x 9 bits (tlast + data). Full when (wr_ptr − rd_ptr) == DEPTH, using log2(DEPTH)+1-bit pointers.
- Input side states:
  - ACCEPT: on each s_axis_tvalid, write {tlast, tdata} at wr_ptr and increment it.
    - On a tlast write: commit_ptr <= wr_ptr+1 and committed-frame count +1.
    - If a byte arrives while full: do not write; wr_ptr <= commit_ptr; o_drop_num +1; go to DISCARD. If that byte has tlast, stay in ACCEPT.
  - DISCARD: ignore bytes; on a tlast byte, return to ACCEPT.
  - i_enable low: bytes ignored; a partially written frame is rewound to commit_ptr, not counted as a drop. After enable rises, writing resumes only after the next tlast (frame-aligned start).
- The output side reads only committed data; uncommitted bytes are never visible.
- Output FSM states: IDLE, H0, H1, H2, H3, DATA.
  - IDLE -> H0 when committed-frame count > 0.
  - H0 byte = {4'hA, i_dst_fpga_index}, sampled on entering H0.
  - H1 byte = CH_ID.
  - H2 byte = seq[15:8].
  - H3 byte = seq[7:0].
  - DATA: buffer bytes from rd_ptr. m_axis_tlast = stored tlast bit.
  - Each state advances only on tvalid && tready. m_axis_tvalid is held high and tdata stable while stalled.
  - On the last DATA beat: committed-frame count −1, seq +1 (16-bit wrap), o_pkt_num +1, then to IDLE. A further header may start on the next cycle, giving 1 idle cycle between packets.
- The buffer read is registered (first-word fall-through via prefetch register), so DATA beats sustain 1 byte/cycle with tready held high.
- Simultaneous commit and packet completion in the same cycle: the count is unchanged.
- Simultaneous write and read when full: the write is still refused. Full is evaluated from pointers registered at the start of the cycle.
- i_enable low does not abort a packet in progress. Already-committed frames still drain.
- rst mid-packet: all state returns to reset values immediately; the partial packet is abandoned.
- o_drop_num saturates at 0xFFFF_FFFF.

Optional Feature:
- Macro I2S_FRAME_PACKER_CRC_EN.
- Defined:
  - After the final DATA beat, a CRC state emits one trailer byte: CRC-8, poly 0x07, init 0x00, MSB-first, over the 4 header bytes and all data bytes.
  - m_axis_tlast moves from the last data byte to the CRC byte.
  - Packet length = frame bytes + 5.
- Undefined: no trailer; packet length = frame bytes + 4.

Test Plan:
- DEPTH=256, dst=3, CH_ID=5. One 8-byte frame 0x00..0x07, tready=1 -> packet A3,05,00,00,00..07; tlast on 0x07; o_pkt_num=1.
- Three back-to-back 4-byte frames, tready low for 50 cycles then high -> three packets with seq 0,1,2; data intact; no drops.
- DEPTH=16. A 20-byte frame, tready=0 -> o_drop_num=1, no packet. The following 6-byte frame is emitted with seq 0.
- Toggle tready randomly every cycle during a 32-byte frame -> byte sequence identical to the tready=1 case; tvalid/tdata stable while stalled.
- Deassert i_enable mid-frame, reassert mid-next-frame -> both frames discarded with o_drop_num=0; the third frame is emitted intact.
- With I2S_FRAME_PACKER_CRC_EN: 1-byte frame 0x00, dst=0, CH_ID=0 -> 6-byte packet A0,00,00,00,00,CRC, where CRC = CRC-8/0x07 of A0 00 00 00 00, checked against a reference model; tlast on the CRC byte.
